// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional byte-lane stores are enabled with the DMEM_BYTE_STROBE_EN macro.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;

   // Word index of a byte address relative to the memory base.
   // The top bit is the borrow of (addr - base); it is set when addr lies below base.
   function automatic logic [WORD_W:0] addr_to_idx(input logic [WORD_W-1:0] addr,
                                                   input logic [WORD_W-1:0] base);
      logic [WORD_W:0] diff;
      diff = {1'b0, addr} - {1'b0, base};
      return {diff[WORD_W], 2'b00, diff[WORD_W-1:2]};
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word memory with per-byte write enables and a registered read port.
// Contents are never reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic [BYTES_PER_WORD-1:0] be,
   input  logic [ADDR_W-1:0]         idx,
   input  logic [WORD_W-1:0]         wdata,
   output logic [WORD_W-1:0]         rdata
);

   logic [WORD_W-1:0] mem_q [2**ADDR_W];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (be[i]) begin
               mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      rdata_q <= mem_q[idx];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the CPU load/store interface: one request at a time, WAIT_CYCLES wait states.
// Define DMEM_BYTE_STROBE_EN to add the req_be byte-lane store mask.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          ADDR_W      = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
   input  logic [3:0]  req_be,
`endif
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              req_ready_q;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic              load_ok_q;

   logic              we_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        be_q;

   logic              accept;
   logic              commit_d;
   logic              cwe_d;
   logic [31:0]       caddr_d;
   logic [31:0]       cwdata_d;
   logic [3:0]        cbe_d;
   logic [WORD_W:0]   idx_d;
   logic              err_d;
   logic [3:0]        req_be_w;
   logic [31:0]       arr_rdata;

`ifdef DMEM_BYTE_STROBE_EN
   assign req_be_w = req_be;
`else
   assign req_be_w = 4'hF;
`endif

   assign accept   = (state_q == IDLE) && req_valid && req_ready_q;
   assign commit_d = (accept && ZERO_WAIT) || ((state_q == WAIT) && (cnt_q == 4'd1));

   // With no wait states the commit happens on the accept edge, so decode straight from the inputs.
   always_comb begin
      caddr_d  = addr_q;
      cwe_d    = we_q;
      cwdata_d = wdata_q;
      cbe_d    = be_q;
      if (state_q == IDLE) begin
         caddr_d  = req_addr;
         cwe_d    = req_we;
         cwdata_d = req_wdata;
         cbe_d    = req_be_w;
      end
      idx_d = addr_to_idx(caddr_d, BASE_ADDR);
      err_d = (caddr_d[1:0] != 2'b00) || idx_d[WORD_W] || ((idx_d[WORD_W-1:0] >> ADDR_W) != '0);
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         be_q    <= req_be_w;
      end
   end

   dmem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .we    (commit_d && cwe_d && !err_d),
      .be    (cbe_d),
      .idx   (idx_d[ADDR_W-1:0]),
      .wdata (cwdata_d),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         load_ok_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  cnt_q       <= WAIT_INIT;
                  req_ready_q <= 1'b0;
                  if (ZERO_WAIT) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= err_d;
                     load_ok_q    <= !cwe_d && !err_d;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= err_d;
                  load_ok_q    <= !cwe_d && !err_d;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  req_ready_q  <= 1'b1;
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  load_ok_q    <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // The array keeps re-reading the same unchanged word during RESP, so gated read data stays stable.
   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = load_ok_q ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (2 wait states at base 0, zero wait states at base 0x100).
// Build with DMEM_BYTE_STROBE_EN defined to exercise byte-lane stores.
module tb_dmem_responder;

   localparam int          NDUT  = 2;
   localparam int          WAIT0 = 2;
   localparam int          WAIT1 = 0;
   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0000_0100;
   localparam int          AW0   = 8;
   localparam int          AW1   = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqValid  [NDUT];
   logic        reqReady  [NDUT];
   logic        reqWe     [NDUT];
   logic [31:0] reqAddr   [NDUT];
   logic [31:0] reqWdata  [NDUT];
   logic [3:0]  reqBe     [NDUT];
   logic        respValid [NDUT];
   logic        respReady [NDUT];
   logic [31:0] respRdata [NDUT];
   logic        respErr   [NDUT];

   int          waitCycles [NDUT];
   longint      baseAddr   [NDUT];
   longint      depth      [NDUT];
   int unsigned modelMem   [NDUT][256];
   bit          modelKnown [NDUT][256];

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(AW0), .BASE_ADDR(BASE0), .WAIT_CYCLES(WAIT0)) u_dut0 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (reqValid[0]),
      .req_ready  (reqReady[0]),
      .req_we     (reqWe[0]),
      .req_addr   (reqAddr[0]),
      .req_wdata  (reqWdata[0]),
`ifdef DMEM_BYTE_STROBE_EN
      .req_be     (reqBe[0]),
`endif
      .resp_valid (respValid[0]),
      .resp_ready (respReady[0]),
      .resp_rdata (respRdata[0]),
      .resp_err   (respErr[0])
   );

   dmem_responder #(.ADDR_W(AW1), .BASE_ADDR(BASE1), .WAIT_CYCLES(WAIT1)) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (reqValid[1]),
      .req_ready  (reqReady[1]),
      .req_we     (reqWe[1]),
      .req_addr   (reqAddr[1]),
      .req_wdata  (reqWdata[1]),
`ifdef DMEM_BYTE_STROBE_EN
      .req_be     (reqBe[1]),
`endif
      .resp_valid (respValid[1]),
      .resp_ready (respReady[1]),
      .resp_rdata (respRdata[1]),
      .resp_err   (respErr[1])
   );

   // Counts one comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference memory: decides error/data from the address rules and updates the word image on good stores.
   task automatic modelAccess(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output bit expErr, output logic [31:0] expData,
                              output bit dataKnown);
      longint      a;
      longint      idx;
      int unsigned mask;
      a         = addr;
      idx       = 0;
      expErr    = 1'b0;
      expData   = 32'h0;
      dataKnown = 1'b1;
      if ((a % 4) != 0 || a < baseAddr[d]) begin
         expErr = 1'b1;
      end else begin
         idx = (a - baseAddr[d]) / 4;
         if (idx >= depth[d]) expErr = 1'b1;
      end
      if (!expErr) begin
         if (we) begin
            mask = 0;
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mask = mask | (32'hFF << (8 * b));
            end
            modelMem[d][idx] = (modelMem[d][idx] & ~mask) | (wdata & mask);
            if (be == 4'hF) modelKnown[d][idx] = 1'b1;
         end else begin
            dataKnown = modelKnown[d][idx];
            expData   = modelMem[d][idx];
         end
      end
   endtask

   // Response contents expected while resp_valid is high.
   task automatic checkResp(input string tag, input int d, input bit we, input bit expErr,
                            input logic [31:0] expData, input bit dataKnown);
      checkOutput({tag, "_err"}, respErr[d], expErr);
      if (we || expErr) checkOutput({tag, "_rdata_zero"}, respRdata[d], 32'h0);
      else if (dataKnown) checkOutput({tag, "_rdata"}, respRdata[d], expData);
   endtask

   // One full transaction on DUT d, with resp_ready held low for `hold` cycles of the response.
   task automatic applyStimulus(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int hold);
      bit          expErr;
      bit          dataKnown;
      logic [31:0] expData;
      int          edges;
      checkOutput("idle_ready", reqReady[d], 1);
      modelAccess(d, we, addr, wdata, be, expErr, expData, dataKnown);
      reqValid[d]  = 1'b1;
      reqWe[d]     = we;
      reqAddr[d]   = addr;
      reqWdata[d]  = wdata;
      reqBe[d]     = be;
      respReady[d] = (hold == 0);
      @(posedge clk); #1;
      reqValid[d] = 1'b0;
      reqWe[d]    = 1'b1;
      reqAddr[d]  = $urandom;
      reqWdata[d] = $urandom;
      edges = 1;
      while (!respValid[d] && edges < 40) begin
         checkOutput("wait_ready_low", reqReady[d], 0);
         @(posedge clk); #1;
         edges++;
      end
      if (!respValid[d]) begin
         checkOutput("resp_timeout", 0, 1);
         return;
      end
      checkOutput("latency", edges, waitCycles[d] + 1);
      checkResp("resp", d, we, expErr, expData, dataKnown);
      checkOutput("resp_ready_low", reqReady[d], 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         checkOutput("bp_valid", respValid[d], 1);
         checkOutput("bp_ready_low", reqReady[d], 0);
         checkResp("bp", d, we, expErr, expData, dataKnown);
      end
      respReady[d] = 1'b1;
      @(posedge clk); #1;
      respReady[d] = 1'b0;
      checkOutput("hs_valid_low", respValid[d], 0);
      checkOutput("hs_ready", reqReady[d], 1);
      checkOutput("hs_rdata", respRdata[d], 32'h0);
      checkOutput("hs_err", respErr[d], 0);
   endtask

   // Random address mix: reused in-range words, top word, misaligned, past the end, below base, anything.
   function automatic logic [31:0] pickAddr(input int d);
      int     sel;
      longint a;
      sel = $urandom_range(0, 9);
      if (sel <= 4)      a = baseAddr[d] + 4 * $urandom_range(0, 7);
      else if (sel == 5) a = baseAddr[d] + 4 * (depth[d] - 1);
      else if (sel == 6) a = baseAddr[d] + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
      else if (sel == 7) a = baseAddr[d] + 4 * depth[d] + 4 * $urandom_range(0, 3);
      else if (sel == 8) a = (baseAddr[d] >= 4) ? baseAddr[d] - 4 : baseAddr[d] + 4 * depth[d];
      else               a = longint'($urandom);
      return a[31:0];
   endfunction

   function automatic logic [3:0] pickBe();
`ifdef DMEM_BYTE_STROBE_EN
      return 4'($urandom_range(0, 15));
`else
      return 4'hF;
`endif
   endfunction

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit          eErr;
      bit          eKnown;
      logic [31:0] eData;
      logic [31:0] a;

      waitCycles = '{WAIT0, WAIT1};
      baseAddr   = '{longint'(BASE0), longint'(BASE1)};
      depth      = '{longint'(2 ** AW0), longint'(2 ** AW1)};
      for (int d = 0; d < NDUT; d++) begin
         reqValid[d]  = 1'b0;
         reqWe[d]     = 1'b0;
         reqAddr[d]   = 32'h0;
         reqWdata[d]  = 32'h0;
         reqBe[d]     = 4'hF;
         respReady[d] = 1'b0;
         for (int i = 0; i < 256; i++) begin
            modelMem[d][i]   = 0;
            modelKnown[d][i] = 1'b0;
         end
      end

      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         checkOutput("reset_ready", reqReady[d], 1);
         checkOutput("reset_valid", respValid[d], 0);
         checkOutput("reset_rdata", respRdata[d], 32'h0);
         checkOutput("reset_err", respErr[d], 0);
      end
      reset = 1'b1;
      @(posedge clk); #1;

      // Directed sequence on the 2-wait-state instance.
      applyStimulus(0, 1'b1, 32'h10, 32'h0000_000F, 4'hF, 0);
      applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
      applyStimulus(0, 1'b0, 32'h12, 32'h0, 4'hF, 0);
      applyStimulus(0, 1'b0, 32'h400, 32'h0, 4'hF, 0);
      applyStimulus(0, 1'b1, 32'h13, 32'hDEAD_BEEF, 4'hF, 0);
      applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 5);
      applyStimulus(0, 1'b1, 32'h20, 32'h55AA_0020, 4'hF, 0);

      // Store aborted by reset during its first wait cycle must not reach memory.
      checkOutput("abort_idle_ready", reqReady[0], 1);
      reqValid[0]  = 1'b1;
      reqWe[0]     = 1'b1;
      reqAddr[0]   = 32'h20;
      reqWdata[0]  = 32'h1234_5678;
      reqBe[0]     = 4'hF;
      respReady[0] = 1'b1;
      @(posedge clk); #1;
      reqValid[0] = 1'b0;
      checkOutput("abort_in_wait", reqReady[0], 0);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      respReady[0] = 1'b0;
      checkOutput("abort_ready", reqReady[0], 1);
      checkOutput("abort_valid", respValid[0], 0);
      checkOutput("abort_rdata", respRdata[0], 32'h0);
      checkOutput("abort_err", respErr[0], 0);
      repeat (4) begin
         @(posedge clk); #1;
         checkOutput("abort_no_resp", respValid[0], 0);
      end
      applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'hF, 0);

`ifdef DMEM_BYTE_STROBE_EN
      applyStimulus(0, 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 0);
      applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
      applyStimulus(0, 1'b1, 32'h14, 32'h0BAD_F00D, 4'b0000, 1);
`endif

      // Zero-wait instance with req_valid held high: one accept every two cycles, nothing dropped.
      respReady[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         a = BASE1 + 32'(4 * (k % 4));
         checkOutput("b2b_ready", reqReady[1], 1);
         reqValid[1] = 1'b1;
         reqWe[1]    = (k < 4);
         reqAddr[1]  = a;
         reqWdata[1] = 32'hC0DE_0000 + 32'(k);
         reqBe[1]    = 4'hF;
         modelAccess(1, (k < 4), a, 32'hC0DE_0000 + 32'(k), 4'hF, eErr, eData, eKnown);
         @(posedge clk); #1;
         checkOutput("b2b_valid", respValid[1], 1);
         checkOutput("b2b_ready_low", reqReady[1], 0);
         checkResp("b2b", 1, (k < 4), eErr, eData, eKnown);
         reqWe[1]    = 1'b1;
         reqAddr[1]  = BASE1;
         reqWdata[1] = $urandom;
         @(posedge clk); #1;
         checkOutput("b2b_done", respValid[1], 0);
      end
      reqValid[1]  = 1'b0;
      respReady[1] = 1'b0;

      // Randomized traffic on both instances.
      for (int d = 0; d < NDUT; d++) begin
         for (int n = 0; n < 60; n++) begin
            applyStimulus(d, 1'($urandom_range(0, 1)), pickAddr(d), $urandom, pickBe(),
                          $urandom_range(0, 3));
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the CPU datapath's load/store interface.
- Accepts one word request at a time (address, write data, write enable) and returns read data or a write acknowledge after a configurable number of wait states.
- Lets the datapath and controller be exercised against a memory with real latency and backpressure instead of a combinational array.
- Sits between the CPU core and the testbench/top level.

Parameters:
- ADDR_W, 8, log2 of memory depth in words (DEPTH = 2**ADDR_W).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 2, wait states between accept and response (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store word, 0 = load word.
- req_addr  input  32  byte address (the ALU result).
- req_wdata  input  32  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  CPU consumes the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; wait counter = 0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation aborts the request in flight; a pending store that has not yet been committed is discarded.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch we, addr and wdata; load the counter with WAIT_CYCLES.
  - If WAIT_CYCLES==0, go to RESP; otherwise go to WAIT.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - When the counter reaches 1, go to RESP on the next edge.
- Commit on the edge that enters RESP:
  - Decode the address: idx = (addr-BASE_ADDR)>>2.
  - err = addr[1:0]!=0, or addr<BASE_ADDR, or idx>=DEPTH.
  - Store with no error: write the array.
  - Load with no error: resp_rdata = array[idx].
  - Error or store: resp_rdata=0. An erroring store leaves memory unchanged.
  - resp_err is registered with the response.
- RESP:
  - resp_valid=1 and req_ready=0.
  - resp_rdata and resp_err are held stable until resp_valid&&resp_ready.
  - On the handshake edge go to IDLE, clear resp_valid, resp_rdata and resp_err.
  - The earliest next accept is the cycle after the handshake.
- Latency: accept edge to resp_valid high is WAIT_CYCLES+1 edges. With WAIT_CYCLES=0, resp_valid is high on the cycle after accept.
- A load following a store to the same address returns the stored value.
- Inputs are ignored outside IDLE. req_valid may stay high and is not lost; it is accepted on return to IDLE.

Optional Feature:
- Macro: DMEM_BYTE_STROBE_EN.
- Defined:
  - Adds input req_be[3:0].
  - A store writes only the byte lanes with req_be[i]=1; lane i is wdata[8i+7:8i].
  - req_be is latched at accept.
  - A store with req_be==0 completes with no write and no error.
- Undefined:
  - No req_be port; every store writes all 4 bytes.

Decomposition:
- Shared package dmem_pkg:
  - state typedef enum {IDLE, WAIT, RESP};
  - WORD_W=32;
  - BYTES_PER_WORD=4;
  - function addr_to_idx.
- Sub-module dmem_array:
  - Synchronous single-port word array.
  - Ports: clk, we, be, idx, wdata, rdata.
  - Registered read; no reset.
  - Instantiated once; the FSM and address decode stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=2, store 0x0000000F to 0x10, resp_ready=1 -> resp_valid high exactly 3 edges after accept, resp_err=0, resp_rdata=0; then load 0x10 -> resp_rdata=0x0000000F.
- Load 0x12 (misaligned) and load BASE_ADDR+4*DEPTH (out of range) -> resp_err=1, resp_rdata=0; store 0xDEADBEEF to 0x13, then load 0x10 -> still 0x0000000F.
- Backpressure: load 0x10 with resp_ready=0 for 5 cycles -> resp_valid, rdata and err held stable, req_ready=0 throughout; raise resp_ready -> IDLE next edge, req_ready=1.
- Reset mid-WAIT: store 0x12345678 to 0x20, pull reset low during the first WAIT cycle -> all outputs return to reset values; load 0x20 then returns the prior contents, not 0x12345678.
- WAIT_CYCLES=0 with back-to-back req_valid held high -> one accept every 2 cycles (accept, RESP with handshake), no request dropped.
- DMEM_BYTE_STROBE_EN defined: store 0xAABBCCDD to 0x10 with req_be=4'b0101 over prior 0x0000000F -> load 0x10 returns 0x00BB00DD.
